io_in_filter: RTL



---
 rtl/io_in_filter.sv | 94 +++++++++
 1 files changed

// File: rtl/io_in_filter.sv
// Pad input conditioning: two-flop synchronizer followed by a consecutive-sample glitch filter.
// Define IO_IN_FILTER_EDGE_EN to build the registered RISE/FALL pulse outputs; otherwise they are tied to 0.
module io_in_filter #(
    parameter int FILT_W   = 3,
    parameter int FILT_LEN = 4
) (
    input  logic IQC,
    input  logic QRT,
    input  logic IE,
    input  logic PAD_inp,
    output logic OQI_out,
    output logic RISE,
    output logic FALL
);

    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_LEN - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    logic              s1_q, s2_q;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              out_q, out_d;
    logic              upd;
    state_t            state;

    // Only s1 may resolve from metastability; the filter sees s2 alone.
    always_ff @(posedge IQC) begin
        if (QRT) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= PAD_inp;
            s2_q <= s1_q;
        end
    end

    // The qualification count doubles as the state encoding.
    assign state = (cnt_q == '0) ? STABLE : QUALIFY;

    always_comb begin
        cnt_d = '0;
        upd   = 1'b0;
        if (IE && (s2_q != out_q)) begin
            unique case (state)
                STABLE: begin
                    if (CNT_LAST == '0) upd   = 1'b1;
                    else                cnt_d = FILT_W'(1);
                end
                QUALIFY: begin
                    if (cnt_q == CNT_LAST) upd   = 1'b1;
                    else                   cnt_d = cnt_q + FILT_W'(1);
                end
                default: cnt_d = '0;
            endcase
        end
        out_d = upd ? s2_q : out_q;
    end

    always_ff @(posedge IQC) begin
        if (QRT) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign OQI_out = out_q;

`ifdef IO_IN_FILTER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge IQC) begin
        if (QRT) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= upd & out_d;
            fall_q <= upd & ~out_d;
        end
    end

    assign RISE = rise_q;
    assign FALL = fall_q;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif

endmodule
